mux_nx1_pipe: RTL and testbench
===============================

Name: mux_nx1_pipe

Overview:
- Parametrised, elastic, pipelined N:1 operand selector for the FPU add/subtract datapath.
- Generalises the fixed 3-code selector to N data inputs plus two forced-value codes: constant and zero.
- Adds a valid/ready handshake, DEPTH register stages, illegal-code flagging and a synchronous flush.
- Sits between operand/exponent sources and the adder, so the selection can be retimed without breaking back-pressure.

Parameters:
- W, 8, data width.
- N, 3, number of data inputs (2..16).
- DEPTH, 2, pipeline register stages (1..4).
- CONST_VAL, 8'h01, value driven for the constant code, zero-extended or truncated to W.
- CW, clog2(N+2), ctrl width (derived localparam, not user-set).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight beats.
- in_valid  in  1  ctrl/D beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- ctrl  in  CW  select code.
- D  in  N*W  flattened inputs; D[k*W +: W] is input k.
- out_valid  out  1  S/sel_err valid.
- out_ready  in  1  downstream accepts.
- S  out  W  selected value.
- sel_err  out  1  beat carried an illegal ctrl code.
- err_cnt  out  8  saturating count of accepted illegal beats.

Behaviour:
- Reset: clk and rst_n; reset is asynchronous and active-low. While rst_n=0, all stage valids, S, sel_err and err_cnt are 0. in_ready is combinational, so it reads 1 once all stages are empty.
- ctrl decode at the accept point:
  - 0..N-1: S = D[ctrl].
  - N: S = CONST_VAL.
  - N+1: S = 0.
  - Other codes: S = 0 and sel_err = 1.
- Each stage holds {valid, S, sel_err}.
- Stage i loads from stage i-1 when stage i is empty or stage i is advancing. The last stage advances when out_valid && out_ready.
- in_ready = (!stage0.valid || stage0 advances) && !flush.
- Latency is DEPTH cycles from accept to out_valid when out_ready is held high. Throughput is one beat per cycle with no bubbles.
- Back-pressure:
  - With out_ready=0, at most DEPTH beats are buffered; then in_ready=0.
  - Order is preserved; no beat is dropped or duplicated.
  - S and sel_err stay stable while out_valid && !out_ready.
- flush=1:
  - All stage valids clear on the next edge; S keeps its value; out_valid=0 from the next cycle.
  - in_ready=0 during flush, so a simultaneous in_valid is not accepted.
  - err_cnt is not cleared by flush.
- err_cnt increments by 1 on each accepted illegal beat and saturates at 255. Only rst_n clears it.
- Inputs are sampled only on accept; ctrl/D changes while not accepted have no effect.
- rst_n asserted mid-operation discards all in-flight beats immediately, with no output glitch beyond the asynchronous clear.

Decomposition:
- Shared package (FPU common):
  - clog2 function.
  - Code offsets SEL_CONST = N and SEL_ZERO = N+1, computed from N.
  - Default CONST_VAL.
- One natural sub-module: pipe_slice, a single elastic register stage (valid + W+1-bit payload, load/advance logic), instantiated DEPTH times via generate.
- Decode and err_cnt stay in the top level.

Test Plan:
- Reset:
  - Stimulus: drive rst_n=0 asynchronously mid-cycle with 2 beats in flight.
  - Required: out_valid=0, S=0, err_cnt=0 immediately; in_ready=1 after release; first beat appears DEPTH=2 cycles after accept.
- Streaming:
  - Stimulus: D = {8'hCC, 8'hBB, 8'hAA}; ctrl 0,1,2,3,4 back-to-back; out_ready=1.
  - Required: S = AA, BB, CC, 01, 00 on consecutive cycles starting 2 cycles after the first accept; sel_err=0; no bubbles.
- Back-pressure:
  - Stimulus: out_ready=0 for 6 cycles while in_valid=1 with ctrl 0,1,2.
  - Required: in_ready drops after 2 accepts; S holds AA; on release, AA, BB, CC are delivered in order with none lost or repeated.
- Illegal codes:
  - Stimulus: ctrl = 5, 6, 7 accepted.
  - Required: S=00, sel_err=1 on each beat; err_cnt=3.
  - Stimulus: 300 illegal beats.
  - Required: err_cnt=255 and holds.
- Flush:
  - Stimulus: flush=1 with in_valid=1 and 2 beats in flight.
  - Required: in_ready=0 that cycle; out_valid=0 next cycle; err_cnt unchanged; the following accepted beat emerges normally.

Source files
------------

// File: rtl/mux_nx1_pipe_pkg.sv
// Shared FPU-common helpers for the pipelined N:1 operand selector:
// width function, forced-value code offsets and the default constant.
package mux_nx1_pipe_pkg;

    localparam logic [7:0] DEF_CONST_VAL = 8'h01;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

    // Forced-value codes sit directly above the N data-input codes.
    function automatic int selConst(input int n);
        return n;
    endfunction

    function automatic int selZero(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/mux_nx1_pipe_slice.sv
// One elastic register stage: holds a valid bit plus payload and refills
// whenever it is empty or its current contents are being taken downstream.
module pipe_slice
    import mux_nx1_pipe_pkg::*;
#(
    parameter int PW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          up_valid_i,
    input  logic [PW-1:0] up_payload_i,
    output logic          up_ready_o,
    input  logic          down_ready_i,
    output logic          valid_o,
    output logic [PW-1:0] payload_o
);

    logic          valid_q;
    logic          valid_d;
    logic [PW-1:0] payload_q;
    logic [PW-1:0] payload_d;

    assign up_ready_o = !valid_q || down_ready_i;
    assign valid_o    = valid_q;
    assign payload_o  = payload_q;

    // Flush drops the valid bit but leaves the payload untouched, so S holds.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (up_ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                payload_d = up_payload_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Elastic, pipelined N:1 operand selector with constant/zero codes,
// illegal-code flagging, a saturating error counter and synchronous flush.
module mux_nx1_pipe
    import mux_nx1_pipe_pkg::*;
#(
    parameter int             W         = 8,
    parameter int             N         = 3,
    parameter int             DEPTH     = 2,
    parameter logic [W-1:0]   CONST_VAL = W'(DEF_CONST_VAL),
    localparam int            CW        = clog2(N + 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   ctrl,
    input  logic [N*W-1:0]  D,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    S,
    output logic            sel_err,
    output logic [7:0]      err_cnt
);

    localparam int SEL_CONST = selConst(N);
    localparam int SEL_ZERO  = selZero(N);
    localparam int PW        = W + 1;

    logic [31:0]      code;
    logic [W-1:0]     decValue;
    logic             decErr;
    logic             accept;
    logic [7:0]       errCnt_q;
    logic [7:0]       errCnt_d;
    logic [DEPTH-1:0] stageValid;
    logic [DEPTH-1:0] stageReady;
    logic [PW-1:0]    stagePayload [DEPTH];

    assign code = 32'(ctrl);

    // Decode happens once at the accept point; later stages only carry the result.
    always_comb begin
        decValue = '0;
        decErr   = 1'b0;
        if (code < 32'(N)) begin
            for (int k = 0; k < N; k++) begin
                if (code == 32'(k)) begin
                    decValue = D[k*W +: W];
                end
            end
        end else if (code == 32'(SEL_CONST)) begin
            decValue = CONST_VAL;
        end else if (code == 32'(SEL_ZERO)) begin
            decValue = '0;
        end else begin
            decErr = 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gStage
        logic          upValid;
        logic [PW-1:0] upPayload;
        logic          downReady;

        if (g == 0) begin : gFirst
            assign upValid   = in_valid;
            assign upPayload = {decErr, decValue};
        end else begin : gInner
            assign upValid   = stageValid[g-1];
            assign upPayload = stagePayload[g-1];
        end

        if (g == DEPTH - 1) begin : gLast
            assign downReady = out_ready;
        end else begin : gMid
            assign downReady = stageReady[g+1];
        end

        pipe_slice #(
            .PW(PW)
        ) uSlice (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush_i      (flush),
            .up_valid_i   (upValid),
            .up_payload_i (upPayload),
            .up_ready_o   (stageReady[g]),
            .down_ready_i (downReady),
            .valid_o      (stageValid[g]),
            .payload_o    (stagePayload[g])
        );
    end

    assign in_ready  = stageReady[0] && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = stageValid[DEPTH-1];
    assign S         = stagePayload[DEPTH-1][W-1:0];
    assign sel_err   = stagePayload[DEPTH-1][W];
    assign err_cnt   = errCnt_q;

    // Only reset clears the counter; flush deliberately leaves it alone.
    always_comb begin
        errCnt_d = errCnt_q;
        if (accept && decErr && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= 8'h00;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of in-flight beats.
module tb_mux_nx1_pipe;

    localparam int W     = 8;
    localparam int N     = 3;
    localparam int DEPTH = 2;
    localparam int CW    = 3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] ctrl;
    logic [N*W-1:0] D;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  S;
    logic          sel_err;
    logic [7:0]    err_cnt;

    typedef struct {
        int         acc;
        logic [7:0] val;
        logic       err;
    } beat_t;

    beat_t q[$];
    int    cyc;
    int    errCnt;
    int    nAssert;
    int    nFail;

    mux_nx1_pipe #(
        .W     (W),
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selection rules as a plain lookup table on the code value.
    function automatic beat_t refBeat(input logic [2:0] c, input logic [23:0] d, input int when);
        beat_t b;
        b.acc = when;
        b.val = 8'h00;
        b.err = 1'b0;
        case (c)
            3'd0:    b.val = d[7:0];
            3'd1:    b.val = d[15:8];
            3'd2:    b.val = d[23:16];
            3'd3:    b.val = 8'h01;
            3'd4:    b.val = 8'h00;
            default: b.err = 1'b1;
        endcase
        return b;
    endfunction

    // Oldest beat is visible once DEPTH cycles have passed since its accept.
    function automatic logic expOutValid();
        if (q.size() == 0) return 1'b0;
        return (q[0].acc + DEPTH) <= cyc;
    endfunction

    function automatic logic expInReady();
        return !flush && ((q.size() < DEPTH) || out_ready);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic ov;
        ov = expOutValid();
        checkVal("out_valid", 32'(out_valid), 32'(ov));
        if (ov) begin
            checkVal("S", 32'(S), 32'(q[0].val));
            checkVal("sel_err", 32'(sel_err), 32'(q[0].err));
        end
        checkVal("in_ready", 32'(in_ready), 32'(expInReady()));
        checkVal("err_cnt", 32'(err_cnt), 32'(errCnt));
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [23:0] d,
                                 input logic ordy, input logic fl, output logic acc);
        logic  pop;
        beat_t b;
        in_valid  = v;
        ctrl      = c;
        D         = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        checkOutput();
        acc = v && expInReady();
        pop = expOutValid() && ordy;
        b   = refBeat(c, d, cyc);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (acc) begin
                q.push_back(b);
                if (b.err && (errCnt < 255)) errCnt++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        acc;
        int          idx;
        logic [23:0] dStream;

        nAssert   = 0;
        nFail     = 0;
        cyc       = 0;
        errCnt    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ctrl      = '0;
        D         = '0;
        dStream   = 24'hCCBBAA;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkVal("reset_out_valid", 32'(out_valid), 32'd0);
        checkVal("reset_S", 32'(S), 32'd0);
        checkVal("reset_err_cnt", 32'(err_cnt), 32'd0);
        checkVal("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back streaming through every legal code
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'(i), dStream, 1'b1, 1'b0, acc);
        repeat (4) applyStimulus(1'b0, 3'd0, dStream, 1'b1, 1'b0, acc);

        // Back-pressure: six stalled cycles, then drain in order
        idx = 0;
        for (int k = 0; k < 40 && (idx < 3 || q.size() > 0); k++) begin
            applyStimulus(idx < 3, 3'(idx), dStream, k >= 6, 1'b0, acc);
            if (acc) idx++;
        end
        checkVal("bp_all_accepted", 32'(idx), 32'd3);

        // Illegal codes
        for (int c = 5; c < 8; c++) applyStimulus(1'b1, 3'(c), 24'($urandom), 1'b1, 1'b0, acc);
        repeat (3) applyStimulus(1'b0, 3'd0, dStream, 1'b1, 1'b0, acc);
        checkVal("err_cnt_three", 32'(err_cnt), 32'd3);

        // Flush with two beats in flight and a competing in_valid
        applyStimulus(1'b1, 3'd0, dStream, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 3'd1, dStream, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 3'd2, dStream, 1'b1, 1'b1, acc);
        #1;
        checkVal("flush_out_valid", 32'(out_valid), 32'd0);
        checkVal("flush_err_cnt", 32'(err_cnt), 32'd3);
        applyStimulus(1'b1, 3'd2, dStream, 1'b1, 1'b0, acc);
        repeat (3) applyStimulus(1'b0, 3'd0, dStream, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-cycle with two beats in flight
        applyStimulus(1'b1, 3'd0, dStream, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 3'd1, dStream, 1'b1, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        errCnt = 0;
        #1;
        checkVal("arst_out_valid", 32'(out_valid), 32'd0);
        checkVal("arst_S", 32'(S), 32'd0);
        checkVal("arst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("arst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 3'd2, dStream, 1'b1, 1'b0, acc);
        repeat (3) applyStimulus(1'b0, 3'd0, dStream, 1'b1, 1'b0, acc);

        // Error counter saturation
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, 3'($urandom_range(7, 5)), 24'($urandom), 1'b1, 1'b0, acc);
        repeat (3) applyStimulus(1'b0, 3'd0, dStream, 1'b1, 1'b0, acc);
        checkVal("err_cnt_sat", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'd6, 24'($urandom), 1'b1, 1'b0, acc);
        repeat (3) applyStimulus(1'b0, 3'd0, dStream, 1'b1, 1'b0, acc);
        checkVal("err_cnt_hold", 32'(err_cnt), 32'd255);

        // Random traffic with occasional flush and stalls
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 24'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
        end
        repeat (5) applyStimulus(1'b0, 3'd0, dStream, 1'b1, 1'b0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
